hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 SHALL have these ports:
- p0_addr_ID  input  4  source 0 register of the instruction in ID.
- p1_addr_ID  input  4  source 1 register of the instruction in ID.
- re_p0_ID, re_p1_ID  input  1 each  the ID instruction reads p0 / p1.
- hlt_ID  input  1  the ID instruction is HLT.
- dst_addr_EX  input  4  destination of the EX instruction.
- re_mem_EX  input  1  the EX instruction is a load.
- branch_taken_EX  input  1  the EX instruction redirects the PC.
- mem_busy  input  1  the data memory has not completed this cycle.
- stall_PC, stall_IF_ID, stall_ID_EX  output  1 each  hold the PC / the IF_ID register / the ID_EX register.
- bubble_ID_EX  output  1  load a NOP into ID_EX.
- flush_IF_ID  output  1  load a NOP into IF_ID.
- stall_all  output  1  freeze every pipeline register, including EX_MEM and MEM_WB.
- halted  output  1  the core is halted.
- mem_timeout  output  1  sticky watchdog error.

Function
REQ-003 SHALL implement an FSM with states RUN, MEM_WAIT and HALT; the reset state is RUN.
REQ-004 SHALL detect a load-use hazard when re_mem_EX=1, dst_addr_EX!=0, and (re_p0_ID and p0_addr_ID==dst_addr_EX) or (re_p1_ID and p1_addr_ID==dst_addr_EX); R0 never causes a hazard.
REQ-005 SHALL set the outputs combinationally from the current state and current inputs. The priority is mem_busy > branch_taken_EX > load-use > hlt_ID.
REQ-006 In RUN with mem_busy=1: stall_all=1 and stall_PC=stall_IF_ID=stall_ID_EX=1; every other output is 0; the next state is MEM_WAIT.
REQ-007 In RUN with branch_taken_EX=1 (mem_busy=0): flush_IF_ID=1 and bubble_ID_EX=1 for that cycle only; a simultaneous load-use hazard or hlt_ID is ignored; the state stays RUN.
REQ-008 In RUN with a load-use hazard only: stall_PC=stall_IF_ID=1 and bubble_ID_EX=1 for exactly one cycle. The next cycle re-evaluates normally, because the load has moved to MEM and the hazard clears.
REQ-009 In RUN with hlt_ID=1 and no higher-priority event: stall_PC=1; the next state is HALT.
REQ-010 In MEM_WAIT: the same outputs as REQ-006 while mem_busy=1. On the first cycle with mem_busy=0, the unit evaluates as RUN (REQ-007 to REQ-009 apply in that same cycle) and the next state follows RUN rules.
REQ-011 In MEM_WAIT, an 8-bit wait counter SHALL increment every cycle and clear on entry to and exit from MEM_WAIT. At count 255, mem_timeout SHALL set to 1 and hold until reset; the FSM stays in MEM_WAIT.
REQ-012 In HALT: halted=1, stall_PC=stall_IF_ID=stall_ID_EX=1 and bubble_ID_EX=0. The only exit from HALT is reset; branch_taken_EX and mem_busy are ignored.
REQ-013 Unless a rule above asserts it, every output SHALL be 0.

Reset
REQ-014 While rst=1: state=RUN, wait counter=0, mem_timeout=0, and halted=0. All combinational outputs SHALL evaluate as RUN with mem_busy forced to 0 and branch_taken_EX forced to 0.
REQ-015 Reset asserted mid-MEM_WAIT or mid-HALT SHALL take effect immediately and asynchronously, with no completion of the pending wait.

Configuration
REQ-016 When HAZ_STATS_EN is defined, the unit SHALL add these outputs:
- lu_stall_cnt  output  16: counts cycles in which REQ-008 fires.
- flush_cnt  output  16: counts cycles in which REQ-007 fires.
- mem_wait_cnt  output  16: counts cycles with stall_all=1.
All three SHALL saturate at 0xFFFF and reset to 0.
REQ-017 When HAZ_STATS_EN is not defined, these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-018 RUN, re_mem_EX=1, dst_addr_EX=3, re_p1_ID=1, p1_addr_ID=3 -> one cycle of stall_PC=stall_IF_ID=bubble_ID_EX=1, then all outputs 0 once the load leaves EX.
REQ-019 Same stimulus with dst_addr_EX=0 -> no stall; all outputs 0.
REQ-020 branch_taken_EX=1 together with the load-use hazard of REQ-018 -> flush_IF_ID=bubble_ID_EX=1, stall_PC=0, state RUN.
REQ-021 mem_busy=1 for 5 cycles while branch_taken_EX=1 -> stall_all=1 for 5 cycles, then flush_IF_ID=1 in cycle 6; with HAZ_STATS_EN, mem_wait_cnt=5 and flush_cnt=1.
REQ-022 mem_busy held high for 300 cycles -> mem_timeout=1 from the cycle the counter reaches 255, still 1 after mem_busy drops; rst pulse -> mem_timeout=0.
REQ-023 hlt_ID=1 in RUN -> halted=1 from the next cycle and stays 1 with branch_taken_EX=1 and mem_busy=1 applied; async rst mid-cycle -> halted=0 immediately.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze and HLT.
// Optional per-event statistics counters are built when HAZ_STATS_EN is defined.
module hazard_ctrl_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p0_addr_ID,
  input  logic [3:0] p1_addr_ID,
  input  logic       re_p0_ID,
  input  logic       re_p1_ID,
  input  logic       hlt_ID,
  input  logic [3:0] dst_addr_EX,
  input  logic       re_mem_EX,
  input  logic       branch_taken_EX,
  input  logic       mem_busy,
  output logic       stall_PC,
  output logic       stall_IF_ID,
  output logic       stall_ID_EX,
  output logic       bubble_ID_EX,
  output logic       flush_IF_ID,
  output logic       stall_all,
  output logic       halted,
  output logic       mem_timeout
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] mem_wait_cnt
`endif
);

  localparam int unsigned WaitW = 8;
  localparam int unsigned StatW = 16;

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_HALT} state_e;

  state_e             state_q, state_d, cur_state;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               busy_eff, br_eff, lu_hazard;

  // While in reset the unit behaves as RUN with memory idle and no branch.
  assign cur_state = rst ? ST_RUN : state_q;
  assign busy_eff  = mem_busy & ~rst;
  assign br_eff    = branch_taken_EX & ~rst;
  assign lu_hazard = re_mem_EX && (dst_addr_EX != 4'd0) &&
                     ((re_p0_ID && (p0_addr_ID == dst_addr_EX)) ||
                      (re_p1_ID && (p1_addr_ID == dst_addr_EX)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_PC      = 1'b0;
    stall_IF_ID   = 1'b0;
    stall_ID_EX   = 1'b0;
    bubble_ID_EX  = 1'b0;
    flush_IF_ID   = 1'b0;
    stall_all     = 1'b0;
    halted        = 1'b0;
    case (cur_state)
      ST_HALT: begin
        halted      = 1'b1;
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        stall_ID_EX = 1'b1;
      end
      default: begin
        if (busy_eff) begin
          stall_all   = 1'b1;
          stall_PC    = 1'b1;
          stall_IF_ID = 1'b1;
          stall_ID_EX = 1'b1;
          state_d     = ST_MEM_WAIT;
          // Counter restarts on entry and saturates so the timeout stays put.
          if (cur_state != ST_MEM_WAIT) wait_cnt_d = '0;
          else if (wait_cnt_q != WaitW'(255)) wait_cnt_d = wait_cnt_q + WaitW'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (br_eff) begin
            flush_IF_ID  = 1'b1;
            bubble_ID_EX = 1'b1;
          end else if (lu_hazard) begin
            stall_PC     = 1'b1;
            stall_IF_ID  = 1'b1;
            bubble_ID_EX = 1'b1;
          end else if (hlt_ID) begin
            stall_PC = 1'b1;
            state_d  = ST_HALT;
          end
        end
      end
    endcase
    if (state_d == ST_MEM_WAIT && wait_cnt_d == WaitW'(255)) mem_timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZ_STATS_EN
  logic [StatW-1:0] lu_stall_cnt_q, lu_stall_cnt_d;
  logic [StatW-1:0] flush_cnt_q, flush_cnt_d;
  logic [StatW-1:0] mem_wait_cnt_q, mem_wait_cnt_d;
  logic             lu_fire, flush_fire;

  assign flush_fire = (cur_state != ST_HALT) && !busy_eff && br_eff;
  assign lu_fire    = (cur_state != ST_HALT) && !busy_eff && !br_eff && lu_hazard;

  // Saturating event counters.
  always_comb begin
    lu_stall_cnt_d = lu_stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    mem_wait_cnt_d = mem_wait_cnt_q;
    if (lu_fire && lu_stall_cnt_q != '1) lu_stall_cnt_d = lu_stall_cnt_q + StatW'(1);
    if (flush_fire && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + StatW'(1);
    if (stall_all && mem_wait_cnt_q != '1) mem_wait_cnt_d = mem_wait_cnt_q + StatW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_stall_cnt_q <= '0;
      flush_cnt_q    <= '0;
      mem_wait_cnt_q <= '0;
    end else begin
      lu_stall_cnt_q <= lu_stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
    end
  end

  assign lu_stall_cnt = lu_stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign mem_wait_cnt = mem_wait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized self-checking bench for hazard_ctrl_unit against a behavioural model.
// Stats outputs are checked when HAZ_STATS_EN is defined.
module tb_hazard_ctrl_unit;

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HALT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] p0_addr_ID, p1_addr_ID, dst_addr_EX;
  logic       re_p0_ID, re_p1_ID, hlt_ID, re_mem_EX, branch_taken_EX, mem_busy;
  logic       stall_PC, stall_IF_ID, stall_ID_EX, bubble_ID_EX, flush_IF_ID;
  logic       stall_all, halted, mem_timeout;
`ifdef HAZ_STATS_EN
  logic [15:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Model: mode, number of wait cycles entered so far, sticky timeout, stats.
  int mode = M_RUN;
  int waited = 0;
  bit to_m = 0;
  int lu_m = 0, fl_m = 0, mw_m = 0;

  hazard_ctrl_unit dut (
    .clk(clk), .rst(rst),
    .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
    .re_p0_ID(re_p0_ID), .re_p1_ID(re_p1_ID), .hlt_ID(hlt_ID),
    .dst_addr_EX(dst_addr_EX), .re_mem_EX(re_mem_EX),
    .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .bubble_ID_EX(bubble_ID_EX), .flush_IF_ID(flush_IF_ID), .stall_all(stall_all),
    .halted(halted), .mem_timeout(mem_timeout)
`ifdef HAZ_STATS_EN
    , .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .mem_wait_cnt(mem_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {stall_PC, stall_IF_ID, stall_ID_EX, bubble_ID_EX,
            flush_IF_ID, stall_all, halted, mem_timeout};
  endfunction

  function automatic bit load_use();
    return re_mem_EX && dst_addr_EX != 0 &&
           ((re_p0_ID && p0_addr_ID == dst_addr_EX) || (re_p1_ID && p1_addr_ID == dst_addr_EX));
  endfunction

  task automatic model_reset();
    mode = M_RUN; waited = 0; to_m = 0; lu_m = 0; fl_m = 0; mw_m = 0;
  endtask

  // Called at a negedge with inputs applied; checks, clocks the model, returns at next negedge.
  task automatic cycle(input string tag);
    logic [7:0] exp;
    int m, nmode;
    bit busy, br, lu_ev, fl_ev, sa_ev;
    #1;
    m = rst ? M_RUN : mode;
    busy = mem_busy && !rst;
    br = branch_taken_EX && !rst;
    exp = 8'h00; nmode = M_RUN; lu_ev = 0; fl_ev = 0; sa_ev = 0;
    if (m == M_HALT) begin
      exp = 8'b1110_0010; nmode = M_HALT;
    end else if (busy) begin
      exp = 8'b1110_0100; nmode = M_WAIT; sa_ev = 1;
    end else if (br) begin
      exp = 8'b0001_1000; fl_ev = 1;
    end else if (load_use()) begin
      exp = 8'b1101_0000; lu_ev = 1;
    end else if (hlt_ID) begin
      exp = 8'b1000_0000; nmode = M_HALT;
    end
    exp[0] = to_m;
    check(tag, int'(outs()), int'(exp));
    @(posedge clk);
    if (!rst) begin
      if (nmode == M_WAIT) waited = (mode == M_WAIT) ? waited + 1 : 1;
      else waited = 0;
      if (waited >= 256) to_m = 1;
      mode = nmode;
      if (lu_ev && lu_m < 65535) lu_m++;
      if (fl_ev && fl_m < 65535) fl_m++;
      if (sa_ev && mw_m < 65535) mw_m++;
    end
    @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
`ifdef HAZ_STATS_EN
    check({tag, "_lu_cnt"}, int'(lu_stall_cnt), lu_m);
    check({tag, "_flush_cnt"}, int'(flush_cnt), fl_m);
    check({tag, "_mw_cnt"}, int'(mem_wait_cnt), mw_m);
`endif
  endtask

  task automatic idle_inputs();
    p0_addr_ID = 0; p1_addr_ID = 0; re_p0_ID = 0; re_p1_ID = 0; hlt_ID = 0;
    dst_addr_EX = 0; re_mem_EX = 0; branch_taken_EX = 0; mem_busy = 0;
  endtask

  // Asynchronous reset pulse asserted mid-cycle, starting and ending at a negedge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_halted_async"}, int'(halted), 0);
    check({tag, "_timeout_async"}, int'(mem_timeout), 0);
    @(negedge clk);
    cycle({tag, "_in_reset"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    check("reset_outputs", int'(outs()), 0);
    cycle("reset_cycle");
    rst = 1'b0;
    cycle("idle_run");

    // Load-use on p1 for one cycle, then the load leaves EX.
    re_mem_EX = 1; dst_addr_EX = 3; re_p1_ID = 1; p1_addr_ID = 3;
    #1 check("lu_stall", int'(outs()), 8'b1101_0000);
    cycle("lu_model");
    re_mem_EX = 0;
    #1 check("lu_cleared", int'(outs()), 0);
    cycle("lu_cleared_model");

    // R0 destination never stalls.
    re_mem_EX = 1; dst_addr_EX = 0; p1_addr_ID = 0;
    #1 check("lu_r0", int'(outs()), 0);
    cycle("lu_r0_model");

    // Branch wins over load-use.
    dst_addr_EX = 3; p1_addr_ID = 3; branch_taken_EX = 1;
    #1 check("br_over_lu", int'(outs()), 8'b0001_1000);
    cycle("br_over_lu_model");
    idle_inputs();
    check_stats("after_lu_br");

    // Five busy cycles with a pending branch, then the flush.
    branch_taken_EX = 1; mem_busy = 1;
    for (int i = 0; i < 5; i++) cycle("busy_br");
    mem_busy = 0;
    #1 check("flush_after_busy", int'(outs()), 8'b0001_1000);
    cycle("flush_after_busy_model");
    idle_inputs();
    check_stats("after_busy_br");

    // Watchdog.
    mem_busy = 1;
    for (int i = 0; i < 300; i++) cycle("long_busy");
    mem_busy = 0;
    cycle("long_busy_exit");
    check("timeout_sticky", int'(mem_timeout), 1);
    check_stats("after_timeout");
    pulse_reset("timeout_rst");
    cycle("post_timeout_rst");

    // HALT ignores branch and memory.
    hlt_ID = 1;
    cycle("hlt_enter");
    hlt_ID = 0; branch_taken_EX = 1; mem_busy = 1;
    #1 check("halted_hold", int'(outs()), 8'b1110_0010);
    for (int i = 0; i < 4; i++) cycle("halt_hold");
    pulse_reset("halt_rst");
    idle_inputs();
    cycle("post_halt_rst");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      p0_addr_ID = 4'($urandom_range(0, 3));
      p1_addr_ID = 4'($urandom_range(0, 3));
      dst_addr_EX = 4'($urandom_range(0, 3));
      re_p0_ID = 1'($urandom);
      re_p1_ID = 1'($urandom);
      re_mem_EX = 1'($urandom);
      branch_taken_EX = ($urandom_range(0, 5) == 0);
      hlt_ID = ($urandom_range(0, 40) == 0);
      if (mem_busy) mem_busy = ($urandom_range(0, 3) != 0);
      else mem_busy = ($urandom_range(0, 12) == 0);
      if (mode == M_HALT && $urandom_range(0, 5) == 0) pulse_reset("rand_rst");
      else cycle("rand");
      if (n % 500 == 499) check_stats("rand_stats");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
